// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared constants for the SPI flash arbiter
package spi_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWN0    = 2'd1;
  localparam logic [1:0] ST_OWN1    = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  localparam int REQ_DSP = 0;
  localparam int REQ_CPU = 1;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for one asynchronous request bit
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - round-robin owner of the shared SPI boot flash
// Only chip-select crosses into sysclk; the SPI datapath is a pure mux on grant.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   HOLDOFF_CYCLES = 4,
  parameter logic CPOL           = 1'b0
) (
  input  logic       i_sysclk,
  input  logic       i_reset_INV,
  input  logic       i_enable,
  input  logic [1:0] i_req_cs_INV,
  input  logic [1:0] i_req_clk,
  input  logic [1:0] i_req_mosi,
  output logic [1:0] o_req_miso,
  output logic       o_flash_clk,
  output logic       o_flash_mosi,
  output logic       o_flash_cs_INV,
  input  logic       i_flash_miso,
  output logic [1:0] o_grant,
  output logic [1:0] o_conflict,
  input  logic       i_conflict_clear
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYCLES - 1);

  logic [1:0] w_s_req;
  logic [1:0] w_elig;
  logic [1:0] w_set;
  logic [1:0] w_next_state;
  logic       w_cs_active;

  logic [1:0] r_state;
  logic [1:0] r_grant;
  logic [1:0] r_stale;
  logic [1:0] r_conflict;
  logic       r_last_owner;
  logic [3:0] r_hold_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk    (i_sysclk),
      .i_resetn (i_reset_INV),
      .i_d      (~i_req_cs_INV[g]),
      .o_q      (w_s_req[g])
    );
  end

  assign w_elig = w_s_req & ~r_stale;

  // w_set marks the requester that loses this cycle: it is flagged and made stale.
  always_comb begin
    w_next_state = r_state;
    w_set        = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          if (w_elig == 2'b11) begin
            w_next_state = r_last_owner ? ST_OWN0 : ST_OWN1;
            w_set        = r_last_owner ? 2'b10 : 2'b01;
          end else if (w_elig[REQ_DSP]) begin
            w_next_state = ST_OWN0;
          end else if (w_elig[REQ_CPU]) begin
            w_next_state = ST_OWN1;
          end
        end
      end
      ST_OWN0: begin
        w_set[REQ_CPU] = w_s_req[REQ_CPU];
        if (!w_s_req[REQ_DSP] || !i_enable) w_next_state = ST_HOLDOFF;
      end
      ST_OWN1: begin
        w_set[REQ_DSP] = w_s_req[REQ_DSP];
        if (!w_s_req[REQ_CPU] || !i_enable) w_next_state = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == 4'd0) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_reset_INV) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_stale      <= 2'b00;
      r_conflict   <= 2'b00;
      r_last_owner <= 1'b1;
      r_hold_cnt   <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_grant    <= {w_next_state == ST_OWN1, w_next_state == ST_OWN0};
      r_stale    <= (r_stale | w_set) & w_s_req;
      r_conflict <= (r_conflict & ~{2{i_conflict_clear}}) | w_set;
      if (w_next_state == ST_OWN0) r_last_owner <= 1'b0;
      else if (w_next_state == ST_OWN1) r_last_owner <= 1'b1;
      if (r_state != ST_HOLDOFF && w_next_state == ST_HOLDOFF) begin
        r_hold_cnt <= HOLD_LOAD;
      end else if (r_state == ST_HOLDOFF && r_hold_cnt != 4'd0) begin
        r_hold_cnt <= r_hold_cnt - 4'd1;
      end
    end
  end

  // Raw CS (not the synchronised copy) so the flash deselects the instant the owner lets go.
  assign w_cs_active = (r_grant[REQ_DSP] & ~i_req_cs_INV[REQ_DSP]) |
                       (r_grant[REQ_CPU] & ~i_req_cs_INV[REQ_CPU]);

  always_comb begin
    o_flash_clk  = CPOL;
    o_flash_mosi = 1'b0;
    if (r_grant[REQ_DSP]) begin
      o_flash_clk  = i_req_clk[REQ_DSP];
      o_flash_mosi = i_req_mosi[REQ_DSP];
    end else if (r_grant[REQ_CPU]) begin
      o_flash_clk  = i_req_clk[REQ_CPU];
      o_flash_mosi = i_req_mosi[REQ_CPU];
    end
  end

  assign o_flash_cs_INV = ~w_cs_active;
  assign o_req_miso[REQ_DSP] = r_grant[REQ_DSP] ? i_flash_miso : 1'b1;
  assign o_req_miso[REQ_CPU] = r_grant[REQ_CPU] ? i_flash_miso : 1'b1;
  assign o_grant    = r_grant;
  assign o_conflict = r_conflict;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

  logic       clk;
  logic       reset_INV;
  logic       enable;
  logic [1:0] req_cs_INV;
  logic [1:0] req_clk;
  logic [1:0] req_mosi;
  logic [1:0] req_miso;
  logic       flash_clk;
  logic       flash_mosi;
  logic       flash_cs_INV;
  logic       flash_miso;
  logic [1:0] grant;
  logic [1:0] conflict;
  logic       conflict_clear;

  int n_checks = 0;
  int n_pass   = 0;

  spi_flash_arbiter #(.SYNC_STAGES(2), .HOLDOFF_CYCLES(4), .CPOL(1'b0)) dut (
    .i_sysclk         (clk),
    .i_reset_INV      (reset_INV),
    .i_enable         (enable),
    .i_req_cs_INV     (req_cs_INV),
    .i_req_clk        (req_clk),
    .i_req_mosi       (req_mosi),
    .o_req_miso       (req_miso),
    .o_flash_clk      (flash_clk),
    .o_flash_mosi     (flash_mosi),
    .o_flash_cs_INV   (flash_cs_INV),
    .i_flash_miso     (flash_miso),
    .o_grant          (grant),
    .o_conflict       (conflict),
    .i_conflict_clear (conflict_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  logic [15:0] dsp_word;
  logic [15:0] miso_word;
  logic [15:0] mosi_cap;
  logic [15:0] miso_cap;
  logic        clk_ok;
  logic        side_ok;
  logic        lock_ok;
  int          fall_at;
  int          got_at;

  initial begin
    reset_INV      = 1'b0;
    enable         = 1'b1;
    req_cs_INV     = 2'b11;
    req_clk        = 2'b10;
    req_mosi       = 2'b10;
    flash_miso     = 1'b0;
    conflict_clear = 1'b0;
    dsp_word       = 16'hA5C3;
    miso_word      = 16'h3C96;
    steps(3);

    check("rst_grant", grant, 2'b00);
    check("rst_conflict", conflict, 2'b00);
    check("rst_flash_cs", flash_cs_INV, 1'b1);
    check("rst_flash_clk", flash_clk, 1'b0);
    check("rst_flash_mosi", flash_mosi, 1'b0);
    check("rst_req_miso", req_miso, 2'b11);
    reset_INV = 1'b1;
    steps(2);

    // single DSP request and 16-bit transfer
    req_cs_INV = 2'b10;
    steps(2);
    check("dsp_grant_edge2", grant, 2'b00);
    step();
    check("dsp_grant_edge3", grant, 2'b01);
    check("dsp_flash_cs", flash_cs_INV, 1'b0);
    mosi_cap = '0;
    miso_cap = '0;
    clk_ok   = 1'b1;
    side_ok  = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      req_mosi[0] = dsp_word[i];
      flash_miso  = miso_word[i];
      req_clk[0]  = 1'b0;
      #2;
      mosi_cap = {mosi_cap[14:0], flash_mosi};
      miso_cap = {miso_cap[14:0], req_miso[0]};
      if (flash_clk !== 1'b0) clk_ok = 1'b0;
      if (req_miso[1] !== 1'b1 || flash_cs_INV !== 1'b0) side_ok = 1'b0;
      req_clk[0] = 1'b1;
      #2;
      if (flash_clk !== 1'b1) clk_ok = 1'b0;
    end
    req_clk[0] = 1'b0;
    check("xfer_mosi", mosi_cap, dsp_word);
    check("xfer_miso", miso_cap, miso_word);
    check("xfer_clk", clk_ok, 1'b1);
    check("xfer_cpu_miso_cs", side_ok, 1'b1);
    check("xfer_conflict", conflict, 2'b00);
    req_cs_INV = 2'b11;
    #1;
    check("release_cs_comb", flash_cs_INV, 1'b1);
    steps(2);
    check("release_grant_edge2", grant, 2'b01);
    step();
    check("release_grant_edge3", grant, 2'b00);
    steps(6);

    // holdoff: CPU requests one cycle after DSP release
    req_cs_INV = 2'b10;
    steps(3);
    check("hold_dsp_grant", grant, 2'b01);
    req_cs_INV = 2'b11;
    step();
    req_cs_INV = 2'b01;
    fall_at = -1;
    got_at  = -1;
    for (int n = 2; n <= 20; n++) begin
      if (got_at < 0) begin
        step();
        if (fall_at < 0 && grant == 2'b00) fall_at = n;
        if (grant == 2'b10) got_at = n;
      end
    end
    check("hold_dsp_fall", fall_at, 3);
    check("hold_cpu_gap", (got_at > 0) && (got_at - fall_at >= 5), 1'b1);
    check("hold_conflict", conflict, 2'b00);

    // reset mid-OWN1
    check("own1_flash_cs", flash_cs_INV, 1'b0);
    reset_INV = 1'b0;
    step();
    check("rst_mid_grant", grant, 2'b00);
    check("rst_mid_flash_cs", flash_cs_INV, 1'b1);
    req_cs_INV = 2'b11;
    steps(2);
    reset_INV = 1'b1;
    steps(3);

    // simultaneous request after reset: DSP wins, CPU locked out
    req_cs_INV = 2'b00;
    steps(3);
    check("tie1_grant", grant, 2'b01);
    check("tie1_conflict", conflict, 2'b10);
    req_cs_INV = 2'b01;
    steps(3);
    check("tie1_dsp_release", grant, 2'b00);
    lock_ok = 1'b1;
    repeat (10) begin
      step();
      if (grant !== 2'b00 || flash_cs_INV !== 1'b1) lock_ok = 1'b0;
    end
    check("tie1_cpu_locked", lock_ok, 1'b1);
    req_cs_INV = 2'b11;
    steps(4);

    // second tie goes to the CPU
    req_cs_INV = 2'b00;
    steps(3);
    check("tie2_grant", grant, 2'b10);
    check("tie2_conflict", conflict, 2'b11);
    conflict_clear = 1'b1;
    step();
    conflict_clear = 1'b0;
    check("clear_vs_set", conflict, 2'b01);
    req_cs_INV = 2'b10;
    steps(3);
    check("tie2_cpu_release", grant, 2'b00);
    lock_ok = 1'b1;
    repeat (10) begin
      step();
      if (grant !== 2'b00 || flash_cs_INV !== 1'b1) lock_ok = 1'b0;
    end
    check("tie2_dsp_locked", lock_ok, 1'b1);
    req_cs_INV = 2'b11;
    steps(4);
    req_cs_INV = 2'b10;
    steps(3);
    check("dsp_retry_grant", grant, 2'b01);

    // enable abort mid-OWN0
    enable = 1'b0;
    step();
    check("abort_grant", grant, 2'b00);
    check("abort_flash_cs", flash_cs_INV, 1'b1);
    lock_ok = 1'b1;
    repeat (8) begin
      step();
      if (grant !== 2'b00) lock_ok = 1'b0;
    end
    check("disabled_no_grant", lock_ok, 1'b1);
    req_cs_INV = 2'b11;
    steps(3);
    enable = 1'b1;
    steps(2);

    // overlap: CPU asserts during OWN0 and holds past DSP release
    conflict_clear = 1'b1;
    step();
    conflict_clear = 1'b0;
    check("clear_conflict", conflict, 2'b00);
    req_cs_INV = 2'b10;
    steps(3);
    check("ovl_dsp_grant", grant, 2'b01);
    req_cs_INV = 2'b00;
    steps(3);
    check("ovl_conflict", conflict, 2'b10);
    check("ovl_still_dsp", grant, 2'b01);
    req_cs_INV = 2'b01;
    steps(3);
    check("ovl_dsp_release", grant, 2'b00);
    lock_ok = 1'b1;
    repeat (10) begin
      step();
      if (grant !== 2'b00 || flash_cs_INV !== 1'b1) lock_ok = 1'b0;
    end
    check("ovl_cpu_locked", lock_ok, 1'b1);
    req_cs_INV = 2'b11;
    steps(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Shares the single board SPI boot/config flash between the DSP (`dsp_spi_*` chip-select 1) and the CPU (`cpu_spi1_1v8_*`), replacing the fixed flash wiring in the CPLD top level. It runs on the internal UFM oscillator (`osc_clk`, 3.3–5.5 MHz). Chip-select requests are synchronised and arbitrated round-robin, and the winner's SPI signals are muxed onto `spi_flash_*`. Late or overlapping requesters are locked out and flagged rather than corrupting the flash bus.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for each request chip-select.
- `HOLDOFF_CYCLES`, default 4: idle sysclk cycles enforced between ownerships, range 1–15.
- `CPOL`, default 0: idle level driven on `flash_clk` when no requester owns the bus.
- Clock and reset: one clock; reset is synchronous and active-low.
- `sysclk` in 1: oscillator clock; all state is on its rising edge.
- `reset_INV` in 1: synchronous active-low reset.
- `enable` in 1: `dsp_bank_enable & sys_enable`; when low, no grants are issued.
- `req_cs_INV` in 2: asynchronous active-low requests; [0] = DSP, [1] = CPU.
- `req_clk`, `req_mosi` in 2: requester SPI clock and data out.
- `req_miso` out 2: flash data returned to each requester.
- `flash_clk`, `flash_mosi`, `flash_cs_INV` out 1: to the flash.
- `flash_miso` in 1: from the flash.
- `grant` out 2: registered one-hot ownership, routed to requester GPIOs.
- `conflict` out 2: sticky flag; the requester lost arbitration or was locked out.
- `conflict_clear` in 1: clears `conflict`.

## Operation
- `s_req[i]` is `~req_cs_INV[i]` after `SYNC_STAGES` flops.
- FSM states are IDLE, OWN0, OWN1 and HOLDOFF.
- IDLE:
  - If `enable` is high and exactly one eligible `s_req` is set, go to OWN of that requester.
  - If both are eligible, grant the one that is not `last_owner`.
  - The loser's `conflict` is set and its `stale` bit is set.
- OWNi:
  - `grant[i]` = 1 and `last_owner` <= i.
  - Exit to HOLDOFF on `!s_req[i]` or `!enable`. An `!enable` exit is an abort; the flash CS drops immediately through the gating.
  - If `s_req[j]` is seen for the other requester j, set `conflict[j]` and `stale[j]`.
- HOLDOFF: a 4-bit counter loads `HOLDOFF_CYCLES-1`, counts down, and returns to IDLE at 0.
- Eligibility: requester i is eligible when `s_req[i]` is set and `stale[i]` = 0. `stale[i]` clears when `s_req[i]` = 0.
  - A requester whose CS was already low across another ownership is never granted mid-frame. It must release and retry.
- Datapath (combinational from registered `own[i]` = `grant[i]`):
  - `flash_cs_INV` = `~(own[i] & ~req_cs_INV[i])`. The raw CS is used so release is immediate.
  - `flash_clk` = `own[i] ? req_clk[i] : CPOL`.
  - `flash_mosi` = `own[i] ? req_mosi[i] : 0`.
  - `req_miso[i]` = `own[i] ? flash_miso : 1`.
- Requester protocol: assert CS, wait for `grant[i]`, then clock. If `conflict[i]` is seen, deassert CS and retry.
- `conflict`: a set and a `conflict_clear` in the same cycle leave the flag set.
- Reset values:
  - State IDLE, `grant` = 00, `conflict` = 00, `stale` = 00.
  - `last_owner` = 1, so the DSP wins the first tie.
  - `flash_cs_INV` = 1, `flash_clk` = `CPOL`, `flash_mosi` = 0, `req_miso` = 11.
- Reset asserted mid-transfer: IDLE at the next edge, and the flash is deselected in the same cycle that `grant` clears.

## Timing
- Grant latency: `SYNC_STAGES+1` rising edges after the falling edge of `req_cs_INV`, plus up to one cycle of sampling uncertainty.
- Release:
  - `flash_cs_INV` rises combinationally, with zero cycles of latency.
  - `grant` falls `SYNC_STAGES+1` edges after the CS rise.
- Turnaround: the next grant comes no earlier than `HOLDOFF_CYCLES+1` edges after `grant` falls.
- Requester clock rates are unconstrained while owned. The datapath is pure mux logic; only CS crosses into `sysclk`.
- `conflict` sets on the same edge as the associated state decision.

## Structure
- Shared package `spi_arb_pkg`:
  - State encoding constants `ST_IDLE`, `ST_OWN0`, `ST_OWN1`, `ST_HOLDOFF`.
  - Requester indices `REQ_DSP` = 0 and `REQ_CPU` = 1.
- Sub-module `sync_bit`: a `SYNC_STAGES`-deep flop chain with reset value 0 (CS deasserted after inversion), instantiated once per requester.
- Everything else (FSM, holdoff counter, `stale`/`conflict` flags, mux) lives in `spi_flash_arbiter`. Target size is about 150–200 lines.

## Test plan
- Single DSP request:
  - Stimulus: `req_cs_INV` = 10, then a 16-bit transfer after `grant` = 01.
  - Required response: `grant` rises at edge 3; the flash sees the DSP's `clk`/`mosi`; `req_miso[0]` follows `flash_miso`; `req_miso[1]` = 1; `conflict` = 00.
- Simultaneous request after reset:
  - Stimulus: both CS fall on the same cycle.
  - Required response: `grant` = 01 and `conflict` = 10. The CPU is not granted until its CS toggles high and back low. The next tie then grants the CPU.
- Overlap:
  - Stimulus: the CPU asserts CS during OWN0 and holds it past the DSP release.
  - Required response: `conflict[1]` sets and the CPU stays ungranted until it releases. `flash_cs_INV` never toggles for the CPU.
- Holdoff:
  - Stimulus: the DSP releases, and the CPU requests one cycle later with `HOLDOFF_CYCLES` = 4.
  - Required response: CPU `grant` ≥ 5 edges after DSP `grant` falls.
- Abort:
  - Stimulus: `enable` drops mid-OWN0, and separately `reset_INV` = 0 mid-OWN1.
  - Required response: `grant` clears in one edge and `flash_cs_INV` = 1 that cycle. `conflict_clear` concurrent with a new conflict leaves the flag set.
